// File: rtl/local_inj_ctrl_pkg.sv
// Shared flit geometry, FSM encodings and the timestamp helper for the
// local injection controller.
package local_inj_ctrl_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int VALID_POS      = 31;
    localparam int TIME_POS       = 16;
    localparam int TIME_WIDTH     = 8;
    localparam int PC_INDEX_WIDTH = 3;

    // The stage reserves the all-ones time code for "no eject candidate".
    localparam logic [TIME_WIDTH-1:0] MAX_TIME = '1;

    typedef logic [DATA_WIDTH-1:0] flit_t;

    typedef enum logic [1:0] {
        INJ_STATE_IDLE    = 2'd0,
        INJ_STATE_WAIT    = 2'd1,
        INJ_STATE_STARVED = 2'd2
    } inj_state_e;

    function automatic flit_t stamp_flit(input flit_t f, input logic [TIME_WIDTH-1:0] t);
        flit_t r;
        r = f;
        r[TIME_POS +: TIME_WIDTH] = t;
        return r;
    endfunction

endpackage

// File: rtl/local_inj_ctrl_if.sv
// NI-side handshake plus the head-flit / grant exchange with the local
// eject/inject stage.
interface local_inj_ctrl_if;
    import local_inj_ctrl_pkg::*;

    logic  ni_valid_i;
    flit_t ni_flit_i;
    logic  ni_ready_o;
    flit_t inj_flit_o;
    logic  inj_grant_i;
    logic  merge_local_i;

    modport master (
        output ni_valid_i, ni_flit_i, inj_grant_i, merge_local_i,
        input  ni_ready_o, inj_flit_o
    );

    modport slave (
        input  ni_valid_i, ni_flit_i, inj_grant_i, merge_local_i,
        output ni_ready_o, inj_flit_o
    );

endinterface

// File: rtl/local_inj_fifo.sv
// Circular injection queue: storage, wrap-around pointers and occupancy.
// Head is read combinationally so the stage sees it with zero latency.
module local_inj_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  push_ok;
    logic                  pop_ok;

    assign push_ok = push && (count_reg != CW'(DEPTH));
    assign pop_ok  = pop  && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign head  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
    assign count = count_reg;

endmodule

// File: rtl/local_inj_ctrl.sv
// Local-port injection controller: queue, flit-count feedback register and
// starvation FSM. Define INJ_TIMESTAMP_EN to stamp pushed flits with a time code.
module local_inj_ctrl
    import local_inj_ctrl_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int STARVE_THRESH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    local_inj_ctrl_if.slave           bus,
    input  logic [PC_INDEX_WIDTH-1:0] num_flit_i,
    output logic [PC_INDEX_WIDTH-1:0] num_flit_o,
    output logic [$clog2(DEPTH):0]    occupancy_o,
    output logic                      starve_o
);

    localparam int         CW     = $clog2(DEPTH) + 1;
    localparam logic [7:0] THRESH = 8'(STARVE_THRESH);

    logic [CW-1:0] count;
    logic [CW-1:0] remaining;
    logic          push;
    logic          pop;
    flit_t         store_flit;
    flit_t         head_flit;

    logic [PC_INDEX_WIDTH-1:0] num_flit_reg;
    logic [7:0]                wait_cnt_reg;
    logic [7:0]                wait_cnt_next;
    inj_state_e                state_reg;
    inj_state_e                state_next;

    // Ready comes from the registered count only: a full queue refuses a push
    // even when a pop happens in the same cycle.
    assign bus.ni_ready_o = (count < CW'(DEPTH));
    assign push           = bus.ni_valid_i && bus.ni_ready_o;
    assign pop            = (count != '0) && (bus.inj_grant_i || bus.merge_local_i);
    assign remaining      = count + CW'(push) - CW'(pop);

`ifdef INJ_TIMESTAMP_EN
    localparam logic [TIME_WIDTH-1:0] TIME_LAST = MAX_TIME - 1'b1;

    logic [TIME_WIDTH-1:0] time_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            time_reg <= '0;
        end else if (time_reg == TIME_LAST) begin
            time_reg <= '0;
        end else begin
            time_reg <= time_reg + 1'b1;
        end
    end

    assign store_flit = stamp_flit(bus.ni_flit_i, time_reg);
`else
    assign store_flit = bus.ni_flit_i;
`endif

    local_inj_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (store_flit),
        .pop     (pop),
        .head    (head_flit),
        .count   (count)
    );

    assign bus.inj_flit_o = head_flit;
    assign occupancy_o    = count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_flit_reg <= '0;
        end else begin
            num_flit_reg <= num_flit_i;
        end
    end

    assign num_flit_o = num_flit_reg;

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if ((count == '0) || pop) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg < THRESH) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= INJ_STATE_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INJ_STATE_IDLE: begin
                if ((count != '0) && (remaining != '0)) begin
                    state_next = INJ_STATE_WAIT;
                end
            end
            INJ_STATE_WAIT: begin
                if (pop) begin
                    state_next = (remaining == '0) ? INJ_STATE_IDLE : INJ_STATE_WAIT;
                end else if (wait_cnt_reg == THRESH) begin
                    state_next = INJ_STATE_STARVED;
                end
            end
            INJ_STATE_STARVED: begin
                if (pop) begin
                    state_next = (remaining == '0) ? INJ_STATE_IDLE : INJ_STATE_WAIT;
                end
            end
            default: state_next = INJ_STATE_IDLE;
        endcase
    end

    always_comb begin
        starve_o = (state_reg == INJ_STATE_STARVED);
    end

endmodule

// File: tb/tb_local_inj_ctrl.sv
// Directed bench for local_inj_ctrl: stimulus queues expected head flits,
// a negedge monitor compares the presented head and retires it on pop.
module tb_local_inj_ctrl;
    import local_inj_ctrl_pkg::*;

    localparam int DEPTH  = 4;
    localparam int THRESH = 16;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic [PC_INDEX_WIDTH-1:0] num_flit_i = '0;
    logic [PC_INDEX_WIDTH-1:0] num_flit_o;
    logic [$clog2(DEPTH):0]    occupancy;
    logic                      starve;

    local_inj_ctrl_if bus ();

    local_inj_ctrl #(
        .DEPTH         (DEPTH),
        .STARVE_THRESH (THRESH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .num_flit_i  (num_flit_i),
        .num_flit_o  (num_flit_o),
        .occupancy_o (occupancy),
        .starve_o    (starve)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    flit_t exp_q[$];
    logic [TIME_WIDTH-1:0] tb_time;

    // Reference time code: the value a push at the coming edge should carry.
    always @(posedge clk) begin
        if (!reset_n) tb_time <= '0;
        else if (tb_time == MAX_TIME - 1'b1) tb_time <= '0;
        else tb_time <= tb_time + 1'b1;
    end

    always @(negedge clk) begin
        flit_t exp;
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            exp = (exp_q.size() != 0) ? exp_q[0] : '0;
            checks++;
            if (bus.inj_flit_o !== exp) begin
                errors++;
                $display("FAIL head: inj_flit_o=%08h expected %08h", bus.inj_flit_o, exp);
            end
            if ((bus.inj_grant_i || bus.merge_local_i) && exp_q.size() != 0) begin
                $display("pop  flit=%08h grant=%0b merge=%0b", exp, bus.inj_grant_i, bus.merge_local_i);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; returns 1ns after the edge so checks follow directly.
    task automatic cycle(input logic v, input flit_t f, input logic g, input logic m, input logic acc);
        logic [TIME_WIDTH-1:0] t;
        flit_t e;
        bus.ni_valid_i    = v;
        bus.ni_flit_i     = f;
        bus.inj_grant_i   = g;
        bus.merge_local_i = m;
        t = tb_time;
        @(posedge clk);
        if (acc) begin
`ifdef INJ_TIMESTAMP_EN
            e = stamp_flit(f, t);
`else
            e = f;
`endif
            exp_q.push_back(e);
            $display("push flit=%08h", e);
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        flit_t fa, fb, fc, fd, fe, ff, fg, fh, fz, fp;
        fa = 32'h8000_00A1; fb = 32'h8000_00B2; fc = 32'h8000_00C3; fd = 32'h8000_00D4;
        fe = 32'h8000_00E5; ff = 32'h8000_00F6; fg = 32'h8000_0107; fh = 32'h8000_0218;
        fz = 32'h8000_0329; fp = 32'h8000_043A;
        bus.ni_valid_i = 1'b0; bus.ni_flit_i = '0; bus.inj_grant_i = 1'b0; bus.merge_local_i = 1'b0;

        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h8BAD_0001, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        bus.ni_valid_i = 1'b0;
        chk("rst_occupancy", occupancy, 0);
        chk("rst_inj_flit", bus.inj_flit_o, 0);
        chk("rst_ready", bus.ni_ready_o, 1);
        chk("rst_num_flit", num_flit_o, 0);
        chk("rst_starve", starve, 0);

        cycle(1'b1, fa, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, fb, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, fc, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, fd, 1'b0, 1'b0, 1'b1);
        chk("full_occupancy", occupancy, 4);
        chk("full_ready", bus.ni_ready_o, 0);
        chk("full_head", bus.inj_flit_o, fa);
        cycle(1'b1, fe, 1'b0, 1'b0, 1'b0);
        chk("fifth_refused", occupancy, 4);

        cycle(1'b1, fe, 1'b1, 1'b0, 1'b0);
        chk("full_pop_occupancy", occupancy, 3);
        chk("full_pop_ready", bus.ni_ready_o, 1);
        cycle(1'b1, fe, 1'b0, 1'b0, 1'b1);
        chk("refill_occupancy", occupancy, 4);

        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("drain_occupancy", occupancy, 0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("grant_empty_occupancy", occupancy, 0);
        chk("grant_empty_starve", starve, 0);

        cycle(1'b1, ff, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < THRESH; i++) begin
            idle();
            chk("starve_early", starve, 0);
        end
        idle();
        chk("starve_set", starve, 1);
        chk("starve_occupancy", occupancy, 1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("merge_starve_clr", starve, 0);
        chk("merge_occupancy", occupancy, 0);
        idle();
        chk("idle_starve", starve, 0);

        num_flit_i = 3'd3;
        idle();
        chk("num_flit_3", num_flit_o, 3);
        num_flit_i = 3'd1;
        idle();
        chk("num_flit_1", num_flit_o, 1);

        cycle(1'b1, fg, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, fh, 1'b1, 1'b0, 1'b1);
        chk("push_pop_occupancy", occupancy, 1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("push_pop_drain", occupancy, 0);

        cycle(1'b1, fz, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b0;
        bus.ni_valid_i = 1'b0;
        idle();
        reset_n = 1'b1;
        chk("midrst_occupancy", occupancy, 0);
        chk("midrst_inj_flit", bus.inj_flit_o, 0);
        for (int i = 0; i < 20 && tb_time != 8'd5; i++) idle();
        cycle(1'b1, fp, 1'b0, 1'b0, 1'b1);
`ifdef INJ_TIMESTAMP_EN
        chk("stamp_5", bus.inj_flit_o[TIME_POS +: TIME_WIDTH], 5);
`else
        chk("unstamped", bus.inj_flit_o, fp);
`endif
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

`ifdef INJ_TIMESTAMP_EN
        for (int i = 0; i < 300 && tb_time != MAX_TIME - 1'b1; i++) idle();
        cycle(1'b1, fa, 1'b0, 1'b0, 1'b1);
        chk("stamp_last", bus.inj_flit_o[TIME_POS +: TIME_WIDTH], 32'(MAX_TIME - 1'b1));
        cycle(1'b1, fb, 1'b1, 1'b0, 1'b1);
        chk("stamp_wrap", bus.inj_flit_o[TIME_POS +: TIME_WIDTH], 0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
`endif
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
